// File: rtl/uart_pkg.sv
// uart_pkg -- shared UART definitions: receiver state encoding, data width
// and the oversample divider helper (also intended for a future uart_tx).
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4,
    PARITY = 3'd5
  } uart_state_e;

  // Clocks per oversample tick, integer-truncated.
  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

  localparam int unsigned UART_DEFAULT_DIV = uart_div(50_000_000, 115_200, 16);

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if -- serial line plus received-byte strobes of the UART receiver.
//   rx              : serial line into the receiver (idle high)
//   uart_data       : last correctly received byte
//   uart_data_valid : one-cycle strobe, uart_data updated
//   framing_error   : one-cycle strobe, stop bit sampled low
//   parity_error    : one-cycle strobe, even-parity mismatch
// slave = receiver side, master = line driver / byte consumer side.
interface uart_rx_if;
  import uart_pkg::*;

  logic                   rx;
  logic [UART_DATA_W-1:0] uart_data;
  logic                   uart_data_valid;
  logic                   framing_error;
  logic                   parity_error;

  modport slave  (input  rx,
                  output uart_data, uart_data_valid, framing_error, parity_error);
  modport master (output rx,
                  input  uart_data, uart_data_valid, framing_error, parity_error);
endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen -- oversample tick generator.
//   clk     : system clock
//   reset   : synchronous, active-high reset
//   restart : restart the divider at 0 (aligns ticks to a start edge)
//   tick    : one-cycle pulse every DIV clocks, DIV = CLK_FREQ/(BAUD*OVERSAMPLE)
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned DIV   = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Free-running 0..DIV-1 divider.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DIV - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = (cnt_q == CNT_W'(DIV - 1));

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver, 8N1 LSB first, oversampled with mid-bit sampling.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : uart_rx_if.slave -- rx in; uart_data, uart_data_valid,
//           framing_error, parity_error out (all strobes one cycle wide)
// Config macro UART_RX_PARITY_EN: adds an even-parity bit after the data
// (8E1); when undefined parity_error is tied 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);

  logic                   rx_meta_q, rx_s_q;
  uart_state_e            state_q;
  logic [OS_W-1:0]        os_cnt_q;
  logic [2:0]             bit_cnt_q;
  logic [UART_DATA_W-1:0] shreg_q;
  logic [UART_DATA_W-1:0] data_q;
  logic                   valid_q, ferr_q;
  logic                   tick;
  logic                   restart;
  logic                   os_last;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q, par_bad_q;
`endif

  // Two-flop synchroniser, idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Realign the tick phase to the detected start edge.
  assign restart = (state_q == IDLE) && !rx_s_q;
  assign os_last = (os_cnt_q == OS_W'(OVERSAMPLE - 1));

  baud_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // Receive FSM with registered strobes; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q  <= START;
            os_cnt_q <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
              os_cnt_q  <= '0;
              bit_cnt_q <= '0;
              // Line back high at mid start bit: treat as a glitch.
              state_q   <= rx_s_q ? IDLE : DATA;
            end else begin
              os_cnt_q <= os_cnt_q + OS_W'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (os_last) begin
              os_cnt_q <= '0;
              shreg_q  <= {rx_s_q, shreg_q[UART_DATA_W-1:1]};
              if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end else begin
              os_cnt_q <= os_cnt_q + OS_W'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (os_last) begin
              os_cnt_q  <= '0;
              // Even parity: data plus parity bit must XOR to 0.
              par_bad_q <= ^{shreg_q, rx_s_q};
              perr_q    <= ^{shreg_q, rx_s_q};
              state_q   <= STOP;
            end else begin
              os_cnt_q <= os_cnt_q + OS_W'(1);
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (os_last) begin
              os_cnt_q <= '0;
              if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
                if (!par_bad_q) begin
                  data_q  <= shreg_q;
                  valid_q <= 1'b1;
                end
`else
                data_q  <= shreg_q;
                valid_q <= 1'b1;
`endif
                state_q <= IDLE;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= BREAK;
              end
            end else begin
              os_cnt_q <= os_cnt_q + OS_W'(1);
            end
          end
        end
        BREAK: begin
          if (rx_s_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.uart_data       = data_q;
  assign bus.uart_data_valid = valid_q;
  assign bus.framing_error   = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error    = perr_q;
`else
  assign bus.parity_error    = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that turns the board's UART RX line into bytes for the colour manager. Each byte is delivered as `uart_data` with a one-cycle `uart_data_valid` strobe, which the colour manager parses as channel, intensity and component commands. Frame format is 8N1 at a fixed baud, LSB first. The receiver uses 16x oversampling with mid-bit sampling and reports framing errors.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz (20 ns period).
- `BAUD`, 115200: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit. Must be even and ≥ 8.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idle level is high.
- `uart_data`  out  8  last correctly received byte; holds its value between frames.
- `uart_data_valid`  out  1  one-cycle pulse when `uart_data` has been updated.
- `framing_error`  out  1  one-cycle pulse when the stop bit is sampled low.
- `parity_error`  out  1  one-cycle pulse on a parity mismatch; tied 0 when parity is compiled out.

## Operation
- **Input synchronisation:** `rx` passes through a 2-flop synchroniser. Both flops reset to 1. The FSM sees only `rx_s`.
- **Oversample tick:** period `DIV = CLK_FREQ / (BAUD*OVERSAMPLE)`, integer-truncated (27 for the defaults).
  - The tick counter free-runs from 0 to DIV-1 and pulses `tick` at DIV-1.
  - It is restarted at 0 when a start edge is detected.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. The tick sub-counter `os_cnt` is 0..OVERSAMPLE-1 and the bit counter `bit_cnt` is 0..7.
- **IDLE:** a falling level (`rx_s`=0) moves to START and clears `os_cnt`.
- **START:** at `os_cnt` = OVERSAMPLE/2-1 (7), sample `rx_s`.
  - If 1: glitch, return to IDLE with no output.
  - If 0: clear `os_cnt`, go to DATA.
- **DATA:** every OVERSAMPLE ticks (`os_cnt` = 15), shift `rx_s` into `shreg[7]` with a right shift, so the data ends up LSB first. After 8 bits go to STOP, or to PARITY when it is enabled.
- **STOP:** sample at `os_cnt` = 15.
  - If 1: `uart_data` ← `shreg` and pulse `uart_data_valid` on the next cycle, then go to IDLE immediately. The idle-high second half of the stop bit is not waited for.
  - If 0: pulse `framing_error`, leave `uart_data` unchanged, go to BREAK.
- **BREAK:** wait for `rx_s` = 1, then go to IDLE. A held-low line never produces bytes.
- **Mutual exclusion:** `uart_data_valid`, `framing_error` and `parity_error` are never high in the same cycle.
- **No backpressure:** the consumer must accept every strobe.

## Timing
- **Reset values:** state IDLE, `uart_data` 0x00, all strobes 0, synchroniser 1, counters 0.
- **Reset during a frame:** abort the frame immediately, emit no strobe, and drop the partial byte.
- **Bit time:** DIV*OVERSAMPLE = 432 clk at the defaults.
- **Latency:** `uart_data_valid` rises 2 (sync) + 1 (register) cycles after the stop-bit mid-sample. That is about 9.5 bit times (≈4104 clk) after the start falling edge.
- **Back-to-back frames:** a start edge arriving right after the stop-bit sample is accepted with no gap needed.
- **Strobe width:** each strobe is exactly 1 clk wide, even at the maximum frame rate.
- **Baud tolerance:** ±3% for an 8N1 frame at OVERSAMPLE = 16.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:**
  - A PARITY state follows DATA and samples one even-parity bit at `os_cnt` = 15.
  - On a mismatch, pulse `parity_error`, do not update `uart_data`, and continue to STOP to check framing.
  - Frame length is 11 bits.
- **Undefined:** no PARITY state, `parity_error` is tied 0, and the frame is 8N1 (10 bits).

## Structure
- **Shared package `uart_pkg`:**
  - state enum constants IDLE/START/DATA/STOP/BREAK/PARITY
  - `UART_DATA_W` = 8
  - a default-DIV helper constant shared with any future `uart_tx`.
- **Sub-module `baud_tick_gen`:** parameters CLK_FREQ, BAUD, OVERSAMPLE; inputs clk, reset, restart; output tick.
- **Top-level `uart_rx`:** holds the synchroniser, FSM, shift register and output registers.

## Test plan
- **Nominal byte:** send 0x72 ('r') at 432 clk/bit → exactly one `uart_data_valid` pulse with `uart_data` = 0x72, about 4104 clk after the start edge, and no error strobes.
- **Start glitch:** drive `rx` low for 100 clk, then high → no strobes, FSM back in IDLE. A following 0x41 is received correctly.
- **Framing error:** send 0x67 with the stop bit held 0, then release `rx` after 2 bit times → one `framing_error` pulse, no valid, `uart_data` keeps its previous value. A subsequent 0x42 is received correctly.
- **Back-to-back frames:** 0x41 then 0x42 with no idle gap → two valid pulses with data 0x41 then 0x42, 10 bit times apart.
- **Reset mid-frame:** assert `reset` for 1 clk during bit 4 of 0x43 → no strobe and all outputs at their reset values. The next 0x72 is received correctly.
- **Parity (with `UART_RX_PARITY_EN` defined):** 0x72 with correct even parity → valid. 0x72 with wrong parity → one `parity_error` pulse and no valid.
